// File: rtl/uart_packet_rx_if.sv
// uart_packet_rx_if
//   Groups the byte-stream input and the packet output of uart_packet_rx.
//   master : byte source / packet consumer (drives byte_valid, byte_in)
//   slave  : the packet receiver (drives the pkt_* outputs and busy)
//   Signals:
//     byte_valid  1-cycle strobe, byte_in valid
//     byte_in     received byte (DBITS)
//     pkt_data    assembled payload, first byte in the MSB slot (DBITS*MAX_LEN)
//     pkt_len     payload length of the last good packet
//     pkt_valid   1-cycle pulse, pkt_data/pkt_len updated
//     pkt_err     1-cycle pulse, frame dropped
//     err_code    01 bad LEN, 10 checksum mismatch, 11 timeout (holds)
//     busy        receiver is inside a frame
interface uart_packet_rx_if #(
  parameter int DBITS   = 8,
  parameter int MAX_LEN = 4
) ();
  logic                     byte_valid;
  logic [DBITS-1:0]         byte_in;
  logic [DBITS*MAX_LEN-1:0] pkt_data;
  logic [7:0]               pkt_len;
  logic                     pkt_valid;
  logic                     pkt_err;
  logic [1:0]               err_code;
  logic                     busy;

  modport master (
    output byte_valid, byte_in,
    input  pkt_data, pkt_len, pkt_valid, pkt_err, err_code, busy
  );

  modport slave (
    input  byte_valid, byte_in,
    output pkt_data, pkt_len, pkt_valid, pkt_err, err_code, busy
  );
endinterface

// File: rtl/uart_packet_rx.sv
// uart_packet_rx
//   Turns a received UART byte stream into checked packets.
//   Frame: SYNC, LEN, LEN payload bytes, CSUM where
//   CSUM = (LEN + payload bytes) mod 2**DBITS.
//   Ports:
//     clk_100MHz  system clock
//     reset       asynchronous, active-high reset
//     bus         uart_packet_rx_if.slave (byte input, packet output, busy)
//   All packet outputs are registered; pkt_valid / pkt_err pulse one cycle
//   after the byte that decides the frame. A mid-frame gap of TO_CYCLES
//   cycles drops the frame with a timeout error.
module uart_packet_rx #(
  parameter int               DBITS     = 8,
  parameter int               MAX_LEN   = 4,
  parameter logic [DBITS-1:0] SYNC      = 8'hA5,
  parameter int               TO_CYCLES = 100000,
  parameter int               TO_BITS   = 17
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  uart_packet_rx_if.slave  bus
);

  localparam int PW = DBITS * MAX_LEN;
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_e;

  state_e             state_q,     state_d;
  logic [7:0]         len_q,       len_d;
  logic [DBITS-1:0]   sum_q,       sum_d;
  logic [7:0]         idx_q,       idx_d;
  logic [PW-1:0]      shadow_q,    shadow_d;
  logic [TO_BITS-1:0] cnt_q,       cnt_d;
  logic [PW-1:0]      pkt_data_q,  pkt_data_d;
  logic [7:0]         pkt_len_q,   pkt_len_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               pkt_err_q,   pkt_err_d;
  logic [1:0]         err_code_q,  err_code_d;

  logic               len_ok_s;

  assign len_ok_s = (bus.byte_in != {DBITS{1'b0}}) &&
                    (bus.byte_in <= DBITS'(MAX_LEN));

  // Next-state and output logic for the frame FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    pkt_data_d  = pkt_data_q;
    pkt_len_d   = pkt_len_q;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;

    // Inter-byte gap counter: only runs while waiting inside a frame.
    if (state_q == S_IDLE || bus.byte_valid) begin
      cnt_d = {TO_BITS{1'b0}};
    end else begin
      cnt_d = cnt_q + TO_BITS'(1);
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (bus.byte_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.byte_in == SYNC) begin
            state_d = S_LEN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LEN: begin
          if (len_ok_s) begin
            len_d    = 8'(bus.byte_in);
            sum_d    = bus.byte_in;
            idx_d    = 8'd0;
            shadow_d = {PW{1'b0}};
            state_d  = S_PAYLOAD;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b01;
            state_d    = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          // Slot 0 is the MSB byte of the packed word.
          for (int k = 0; k < MAX_LEN; k++) begin
            if (idx_q == 8'(k)) begin
              shadow_d[PW-1-DBITS*k -: DBITS] = bus.byte_in;
            end else begin
              shadow_d[PW-1-DBITS*k -: DBITS] = shadow_q[PW-1-DBITS*k -: DBITS];
            end
          end
          sum_d = sum_q + bus.byte_in;
          idx_d = idx_q + 8'd1;
          if ((idx_q + 8'd1) == len_q) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_CSUM: begin
          if (bus.byte_in == sum_q) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = shadow_q;
            pkt_len_d   = len_q;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b10;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE && cnt_q == TO_LAST) begin
      pkt_err_d  = 1'b1;
      err_code_d = 2'b11;
      state_d    = S_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      sum_q       <= {DBITS{1'b0}};
      idx_q       <= 8'd0;
      shadow_q    <= {PW{1'b0}};
      cnt_q       <= {TO_BITS{1'b0}};
      pkt_data_q  <= {PW{1'b0}};
      pkt_len_q   <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      pkt_data_q  <= pkt_data_d;
      pkt_len_q   <= pkt_len_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.pkt_data  = pkt_data_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
